// File: rtl/bcd_addsub_seq.sv
// Sequential signed-magnitude BCD adder/subtractor built around one shared
// single-digit BCD adder slice, processing one digit per clock, LSD first.
module bcd_addsub_seq #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic              a_sign,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic              b_sign,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic              busy,
  output logic              done,
  output logic              res_sign,
  output logic [4*NDIG-1:0] res_bcd,
  output logic              ovf,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_RECOMP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          a_sign_q, a_sign_d;
  logic          eff_sub_q, eff_sub_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  res_q, res_d;
  logic          res_sign_q, res_sign_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [3:0]    sl_a, sl_b, sl_sum;
  logic          sl_cin, sl_cout;
  logic [4:0]    sl_raw;
  logic [W-1:0]  a_sh, b_sh, r_sh, dig_mask, dig_val;
  logic          last_dig, go_done, bad_digit;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign a_sh      = a_q >> {idx_q, 2'b00};
  assign b_sh      = b_q >> {idx_q, 2'b00};
  assign r_sh      = res_q >> {idx_q, 2'b00};
  assign last_dig  = (idx_q == IW'(NDIG - 1));
  assign bad_digit = has_bad_digit(a_bcd) | has_bad_digit(b_bcd);

  // Shared slice operand selection: ADD uses a + b (or nines-complement of b),
  // RECOMP turns the stored result into its tens complement digit by digit.
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_cin = 1'b0;
    if (state_q == S_ADD) begin
      sl_a   = a_sh[3:0];
      sl_b   = eff_sub_q ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
      sl_cin = (idx_q == '0) ? eff_sub_q : carry_q;
    end else if (state_q == S_RECOMP) begin
      sl_a   = 4'd9 - r_sh[3:0];
      sl_b   = '0;
      sl_cin = (idx_q == '0) ? 1'b1 : carry_q;
    end
  end

  always_comb begin
    sl_raw  = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0000, sl_cin};
    sl_cout = (sl_raw > 5'd9);
    sl_sum  = sl_cout ? (sl_raw[3:0] + 4'd6) : sl_raw[3:0];
  end

  assign dig_mask = W'(4'hF) << {idx_q, 2'b00};
  assign dig_val  = W'(sl_sum) << {idx_q, 2'b00};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    a_sign_d   = a_sign_q;
    eff_sub_d  = eff_sub_q;
    carry_d    = carry_q;
    res_d      = res_q;
    res_sign_d = res_sign_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    go_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d        = a_bcd;
          b_d        = b_bcd;
          a_sign_d   = a_sign;
          eff_sub_d  = a_sign ^ b_sign ^ op;
          idx_d      = '0;
          carry_d    = 1'b0;
          res_d      = '0;
          res_sign_d = 1'b0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
          err_d      = bad_digit;
          if (bad_digit) go_done = 1'b1;
          else           state_d = S_ADD;
        end
      end
      S_ADD: begin
        res_d   = (res_q & ~dig_mask) | dig_val;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (last_dig) begin
          idx_d = '0;
          if (!eff_sub_q) begin
            ovf_d      = sl_cout;
            res_sign_d = a_sign_q;
            go_done    = 1'b1;
          end else if (sl_cout) begin
            res_sign_d = a_sign_q;
            go_done    = 1'b1;
          end else begin
            res_sign_d = ~a_sign_q;
            state_d    = S_RECOMP;
          end
        end
      end
      S_RECOMP: begin
        res_d   = (res_q & ~dig_mask) | dig_val;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (last_dig) begin
          idx_d   = '0;
          go_done = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Negative zero is squashed on entry so the sign is already final while done is high.
    if (go_done) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      if (res_d == '0) res_sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_sign_q   <= 1'b0;
      eff_sub_q  <= 1'b0;
      carry_q    <= 1'b0;
      res_q      <= '0;
      res_sign_q <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_sign_q   <= a_sign_d;
      eff_sub_q  <= eff_sub_d;
      carry_q    <= carry_d;
      res_q      <= res_d;
      res_sign_q <= res_sign_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_sign = res_sign_q;
  assign res_bcd  = res_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq: expected results come from an integer
// signed-magnitude model and are compared when done pulses.
module tb_bcd_addsub_seq;

  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;
  localparam int MOD  = 10 ** NDIG;

  logic         clk = 1'b0;
  logic         rst_n, start, op, a_sign, b_sign;
  logic [W-1:0] a_bcd, b_bcd;
  logic         busy, done, res_sign, ovf, err;
  logic [W-1:0] res_bcd;

  typedef struct {
    logic         sign;
    logic [W-1:0] bcd;
    logic         ovf;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t last_e;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  bcd_addsub_seq #(.NDIG(NDIG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_sign(a_sign), .a_bcd(a_bcd), .b_sign(b_sign), .b_bcd(b_bcd),
    .busy(busy), .done(done), .res_sign(res_sign), .res_bcd(res_bcd),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic bad_bcd(input logic [W-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] v;
    int t;
    t = x;
    v = '0;
    for (int i = 0; i < NDIG; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  function automatic exp_t model(input logic o, input logic as, input logic [W-1:0] a,
                                 input logic bs, input logic [W-1:0] b);
    exp_t e;
    int ma, mb, m;
    e.sign = 1'b0; e.bcd = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = NDIG + 1;
    if (bad_bcd(a) || bad_bcd(b)) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    ma = bcd2int(a);
    mb = bcd2int(b);
    if ((as ^ bs ^ o) == 1'b0) begin
      m      = ma + mb;
      e.ovf  = (m >= MOD);
      m      = m % MOD;
      e.sign = as;
    end else if (ma >= mb) begin
      m      = ma - mb;
      e.sign = as;
    end else begin
      m      = mb - ma;
      e.sign = ~as;
      e.lat  = 2 * NDIG + 1;
    end
    if (m == 0) e.sign = 1'b0;
    e.bcd = int2bcd(m);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_bcd", 32'(res_bcd), 32'(mon_e.bcd));
        check("res_sign", 32'(res_sign), 32'(mon_e.sign));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
        check("err", 32'(err), 32'(mon_e.err));
        check("latency", 32'(cyc - start_cyc + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic o, input logic as, input logic [W-1:0] a,
                       input logic bs, input logic [W-1:0] b);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    op = o; a_sign = as; a_bcd = a; b_sign = bs; b_bcd = b;
    start = 1'b1;
    last_e = model(o, as, a, bs, b);
    sb_q.push_back(last_e);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // noise: keep re-asserting start with junk operands until done, including the DONE cycle
  task automatic run_op(input logic o, input logic as, input logic [W-1:0] a,
                        input logic bs, input logic [W-1:0] b, input logic noise);
    issue(o, as, a, bs, b);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) break;
      if (noise) begin
        start  = 1'b1;
        op     = ~op;
        a_bcd  = W'($urandom);
        b_bcd  = W'($urandom);
        a_sign = ~a_sign;
      end
    end
    if (sb_q.size() != 0) begin
      check("timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
    if (noise) begin
      @(negedge clk);
      check("busy_after_done_start", 32'(busy), 32'd0);
      start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0;
    a_sign = 1'b0; b_sign = 1'b0; a_bcd = '0; b_bcd = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'({res_sign, res_bcd, ovf, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 1'b0);
    run_op(1'b0, 1'b0, 12'h999, 1'b0, 12'h001, 1'b0);
    run_op(1'b1, 1'b0, 12'h100, 1'b0, 12'h250, 1'b0);
    run_op(1'b0, 1'b1, 12'h250, 1'b0, 12'h250, 1'b0);
    run_op(1'b0, 1'b0, 12'h1A3, 1'b0, 12'h005, 1'b0);
    run_op(1'b0, 1'b0, 12'h005, 1'b0, 12'h007, 1'b0);
    run_op(1'b0, 1'b0, 12'h010, 1'b0, 12'h9F0, 1'b0);
    run_op(1'b1, 1'b1, 12'h999, 1'b1, 12'h999, 1'b0);
    run_op(1'b0, 1'b1, 12'h500, 1'b1, 12'h600, 1'b0);
    run_op(1'b1, 1'b1, 12'h000, 1'b0, 12'h001, 1'b0);

    run_op(1'b1, 1'b0, 12'h100, 1'b0, 12'h250, 1'b1);
    run_op(1'b0, 1'b0, 12'h321, 1'b1, 12'h021, 1'b1);

    @(negedge clk); @(negedge clk); @(negedge clk);
    check("hold_res", 32'(res_bcd), 32'(last_e.bcd));
    check("hold_sign", 32'(res_sign), 32'(last_e.sign));

    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] ra, rb;
      ra = int2bcd(int'($urandom_range(0, MOD - 1)));
      rb = int2bcd(int'($urandom_range(0, MOD - 1)));
      run_op(1'($urandom), 1'($urandom), ra, 1'($urandom), rb, 1'b0);
    end

    issue(1'b1, 1'b0, 12'h100, 1'b0, 12'h250);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_res", 32'({res_sign, res_bcd, ovf, err}), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, 1'b0);
    run_op(1'b1, 1'b0, 12'h100, 1'b0, 12'h250, 1'b0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
